// File: rtl/rv32_m_responder_pkg.sv
// Shared definitions for the external RV32M multiply/divide responder.
//   XLEN_DEF  : default operand/result width
//   funct3_e  : M-extension funct3 encodings, used by requester and responder
//   state_e   : responder FSM states
//   f3_is_div / f3_is_rem : opcode class helpers
package rv32_m_responder_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  // DIV/DIVU/REM/REMU all have funct3[2] set.
  function automatic logic f3_is_div(input funct3_e f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_rem(input funct3_e f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/rv32_m_responder_if.sv
// External multiply/divide handshake between pipeline (master) and
// coprocessor (slave).
//   i_en           : one-cycle start pulse, operands valid with it
//   i_rs1 / i_rs2  : operand A / operand B
//   i_f3           : funct3 selecting the M operation
//   o_res          : registered result, held until the next ack
//   o_ack          : one-cycle completion strobe
interface rv32_m_responder_if
  import rv32_m_responder_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) ();

  logic            i_en;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [2:0]      i_f3;
  logic [XLEN-1:0] o_res;
  logic            o_ack;

  modport master (
    output i_en, i_rs1, i_rs2, i_f3,
    input  o_res, o_ack
  );

  modport slave (
    input  i_en, i_rs1, i_rs2, i_f3,
    output o_res, o_ack
  );

endinterface

// File: rtl/rv32_m_operand_prep.sv
// Combinational operand conditioning for the M responder.
//   rs1, rs2, f3   : raw operands and funct3
//   mag_a, mag_b   : operand magnitudes (two's complement negated when the
//                    operand is treated as signed and is negative)
//   res_neg        : final result must be negated (product/quotient:
//                    sign(A)^sign(B); remainder: sign(A))
//   special        : divide-by-zero or signed overflow; result known now
//   special_res    : result for the special case
module rv32_m_operand_prep
  import rv32_m_responder_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      f3,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            res_neg,
  output logic            special,
  output logic [XLEN-1:0] special_res
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  funct3_e op;
  logic    a_signed;
  logic    b_signed;
  logic    neg_a;
  logic    neg_b;
  logic    div_zero;
  logic    overflow;

  always_comb begin
    op       = funct3_e'(f3);
    a_signed = (op == F3_MULH) || (op == F3_MULHSU) ||
               (op == F3_DIV)  || (op == F3_REM);
    b_signed = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    neg_a    = a_signed && rs1[XLEN-1];
    neg_b    = b_signed && rs2[XLEN-1];

    mag_a    = neg_a ? -rs1 : rs1;
    mag_b    = neg_b ? -rs2 : rs2;
    res_neg  = f3_is_rem(op) ? neg_a : (neg_a ^ neg_b);

    div_zero = f3_is_div(op) && (rs2 == '0);
    overflow = ((op == F3_DIV) || (op == F3_REM)) &&
               (rs1 == INT_MIN) && (rs2 == '1);
    special  = div_zero || overflow;

    special_res = '0;
    if (div_zero) begin
      special_res = f3_is_rem(op) ? rs1 : '1;
    end else if (overflow) begin
      special_res = f3_is_rem(op) ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/rv32_m_responder.sv
// RV32M external coprocessor, responder side of the EX-stage handshake.
// Iterative shift-add multiply / restoring divide, XLEN iterations per op;
// divide-by-zero and signed overflow complete in a single cycle.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-low reset
//   bus   : rv32_m_responder_if slave (i_en/i_rs1/i_rs2/i_f3 in,
//           o_res/o_ack out)
module rv32_m_responder
  import rv32_m_responder_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rv32_m_responder_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  funct3_e             f3_q, f3_d;
  logic                neg_q, neg_d;
  logic                special_q, special_d;
  // a_q: multiplicand, or dividend shifting out / quotient shifting in,
  //      or the precomputed special-case result.
  logic [XLEN-1:0]     a_q, a_d;
  // b_q: multiplier (consumed LSB first) or divisor.
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                ack_q, ack_d;

  logic [XLEN-1:0]     prep_mag_a;
  logic [XLEN-1:0]     prep_mag_b;
  logic                prep_neg;
  logic                prep_special;
  logic [XLEN-1:0]     prep_special_res;

  rv32_m_operand_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .rs1         (bus.i_rs1),
    .rs2         (bus.i_rs2),
    .f3          (bus.i_f3),
    .mag_a       (prep_mag_a),
    .mag_b       (prep_mag_b),
    .res_neg     (prep_neg),
    .special     (prep_special),
    .special_res (prep_special_res)
  );

  // Iteration arithmetic.
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_trial;
  logic [XLEN:0]       div_diff;
  logic                div_qbit;
  logic [2*XLEN-1:0]   prod_signed;
  logic [XLEN-1:0]     quo_signed;
  logic [XLEN-1:0]     rem_signed;
  logic [XLEN-1:0]     final_res;

  always_comb begin
    // Multiply: add multiplicand into the upper half, then shift the whole
    // accumulator right; after XLEN steps it holds the full product.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : '0)};
    // Divide: the XLEN-bit stored remainder plus the next dividend bit form
    // the XLEN+1-bit partial remainder; the restored remainder always fits
    // back in XLEN bits because it is below the divisor.
    div_trial = {rem_q, a_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, b_q};
    div_qbit  = ~div_diff[XLEN];

    prod_signed = neg_q ? -acc_q : acc_q;
    quo_signed  = neg_q ? -a_q   : a_q;
    rem_signed  = neg_q ? -rem_q : rem_q;

    if (special_q) begin
      final_res = a_q;
    end else begin
      case (f3_q)
        F3_MUL:                         final_res = prod_signed[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU:   final_res = prod_signed[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:                final_res = quo_signed;
        default:                        final_res = rem_signed;
      endcase
    end
  end

  // FSM: state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_en) begin
          state_d = prep_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and datapath updates.
  always_comb begin
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    special_d = special_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    res_d     = res_q;
    ack_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_en) begin
          cnt_d     = '0;
          f3_d      = funct3_e'(bus.i_f3);
          neg_d     = prep_neg;
          special_d = prep_special;
          a_d       = prep_special ? prep_special_res : prep_mag_a;
          b_d       = prep_mag_b;
          acc_d     = '0;
          rem_d     = '0;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (f3_is_div(f3_q)) begin
          rem_d = div_qbit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], div_qbit};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          b_d   = b_q >> 1;
        end
      end
      ST_DONE: begin
        res_d = final_res;
        ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q     <= '0;
      f3_q      <= F3_MUL;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.o_res = res_q;
  assign bus.o_ack = ack_q;

endmodule

// File: doc/rv32_m_responder.md
Name: rv32_m_responder

Overview:
- External RV32M coprocessor: the responder end of the EX-stage external multiply/divide handshake.
- Accepts a one-cycle start pulse carrying operands and funct3, computes the MUL/DIV/REM family iteratively, and returns the result with a one-cycle ack.
- Sits outside the core, one per hart, on the same clock as the pipeline.

Parameters:
XLEN  32  operand/result width; iteration count equals XLEN

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-low
i_en  in  1  start pulse; operands valid in the same cycle
i_rs1  in  XLEN  operand A (multiplicand / dividend)
i_rs2  in  XLEN  operand B (multiplier / divisor)
i_f3  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
o_res  out  XLEN  result; registered, held until the next ack
o_ack  out  1  completion; high exactly one cycle, o_res valid in that cycle

Behaviour:
- Reset (i_rst=0, async): state IDLE, o_ack=0, o_res=0, counter and datapath registers cleared. Reset mid-operation aborts the operation; no ack is produced.
- FSM states:
  - IDLE: on i_en=1 at edge E0, capture i_rs1/i_rs2/i_f3. Next state is DONE for special cases, otherwise CALC.
  - CALC: one iteration per edge, E1..E32. Counter reaches XLEN-1 at E32 -> DONE.
  - DONE: at the next edge load o_res, set o_ack=1, go to IDLE. o_ack returns to 0 at the following edge.
- Latency: normal ops ack visible after E33; special cases ack visible after E1. Fixed, data-independent.
- i_en outside IDLE (CALC, DONE, ack cycle) is ignored; no queueing.
- i_en while o_ack=1 (state IDLE) is accepted.
- Signedness at capture: take operand magnitudes; operand is signed for MULH (A, B), MULHSU (A only), DIV/REM (A, B). Record the result sign:
  - product: sign(A) xor sign(B)
  - quotient: sign(A) xor sign(B)
  - remainder: sign(A)
- Multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per cycle. Negate the 2*XLEN result if the sign is set. MUL returns the low word (signedness irrelevant); MULH/MULHSU/MULHU return the high word.
- Divide: restoring division, one quotient bit per cycle, XLEN-bit quotient and XLEN+1-bit partial remainder. Negate quotient/remainder per the recorded sign in DONE.
- Special cases (single-cycle path, detected at capture):
  - divisor=0: DIV/DIVU -> all ones; REM/REMU -> A unchanged.
  - signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- o_res changes only in the ack cycle.

Decomposition:
- funct3 opcode constants go in the shared defines header beside the external-M interface macro, used by both ends.
- Sign/special-case detection is natural as one combinational sub-module: rv32_m_operand_prep. Outputs magnitudes, result-sign flags, special flag and special result.
- FSM and iterative datapath stay in rv32_m_responder.

Test Plan:
- MUL A=7, B=0xFFFFFFFD pulse at E0 -> o_ack high only after E33, o_res=0xFFFFFFEB; o_ack low after E34.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV 100/0 -> 0xFFFFFFFF, REMU 100/0 -> 100, each with ack after E1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2(-14); REM -> 0xFFFFFFFE(-2); REMU 100/7 -> 2.
- i_en re-pulsed at E10 with different operands during CALC -> ignored; single ack carries the first result. New i_en in the ack cycle -> accepted, second ack 33 edges later.
- Assert i_rst low at E15 of DIVU, release 3 cycles later -> o_ack stays 0, o_res=0; next DIVU 9/2 -> 4 after normal latency.
